// File: rtl/pipe_pkg.sv
// Shared types, constants and helpers for the pipe_stage_reg pipeline latch.
// The width-parametrised fields (payload, T_new) travel beside slice_t.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [4:0]  EXC_NONE       = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
        logic        valid;
    } slice_t;

    // T_new countdown: saturates at zero instead of wrapping
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slice.sv
// One pipeline slice: reset > flush > bubble > load > hold.
// A bubble keeps pc/bd so EPC stays correct for an interrupt taken on it.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int          N_WORDS    = 4,
    parameter int          TNEW_W     = 3,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   bubble,
    input  logic                   flush,
    input  slice_t                 src,
    input  logic [32*N_WORDS-1:0]  src_payload,
    input  logic [TNEW_W-1:0]      src_t_new,
    output slice_t                 slice_out,
    output logic [32*N_WORDS-1:0]  payload_out,
    output logic [TNEW_W-1:0]      t_new_out
);

    slice_t                slice_q, slice_d;
    logic [32*N_WORDS-1:0] payload_q, payload_d;
    logic [TNEW_W-1:0]     t_new_q, t_new_d;

    always_comb begin
        slice_d   = slice_q;
        payload_d = payload_q;
        t_new_d   = t_new_q;
        if (flush) begin
            slice_d.pc       = HANDLER_PC;
            slice_d.instr    = '0;
            slice_d.exc_code = EXC_NONE;
            slice_d.bd       = 1'b0;
            slice_d.valid    = 1'b0;
            payload_d        = '0;
            t_new_d          = '0;
        end else if (bubble) begin
            slice_d.pc       = src.pc;
            slice_d.instr    = '0;
            slice_d.exc_code = EXC_NONE;
            slice_d.bd       = src.bd;
            slice_d.valid    = 1'b0;
            payload_d        = '0;
            t_new_d          = '0;
        end else if (load) begin
            slice_d   = src;
            payload_d = src_payload;
            t_new_d   = TNEW_W'(sat_dec(32'(src_t_new)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slice_q.pc       <= RESET_PC;
            slice_q.instr    <= '0;
            slice_q.exc_code <= EXC_NONE;
            slice_q.bd       <= 1'b0;
            slice_q.valid    <= 1'b0;
            payload_q        <= '0;
            t_new_q          <= '0;
        end else begin
            slice_q   <= slice_d;
            payload_q <= payload_d;
            t_new_q   <= t_new_d;
        end
    end

    assign slice_out   = slice_q;
    assign payload_out = payload_q;
    assign t_new_out   = t_new_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline latch built from DEPTH chained slices.
// Optional PIPE_STAGE_STAT_EN adds stall_cnt / bubble_cnt statistics outputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          N_WORDS    = 4,
    parameter int          DEPTH      = 1,
    parameter int          TNEW_W     = 3,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  req_clr,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    input  logic [32*N_WORDS-1:0] payload,
    input  logic [TNEW_W-1:0]     t_new,
    input  logic [4:0]            exc_code,
    input  logic                  bd,
    output logic [31:0]           pc_n,
    output logic [31:0]           instr_n,
    output logic [32*N_WORDS-1:0] payload_n,
    output logic [TNEW_W-1:0]     fwd_t_new,
    output logic [4:0]            exc_code_n,
    output logic                  bd_n,
    output logic                  valid_n
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    slice_t                hdr_q     [DEPTH];
    logic [32*N_WORDS-1:0] payload_q [DEPTH];
    logic [TNEW_W-1:0]     t_new_q   [DEPTH];
    slice_t                in_hdr;

    assign in_hdr = '{pc: pc, instr: instr, exc_code: exc_code, bd: bd, valid: 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slice
            slice_t                src;
            logic [32*N_WORDS-1:0] src_payload;
            logic [TNEW_W-1:0]     src_t_new;
            logic                  bubble;

            // Only the head slice takes the bubble; later slices keep advancing
            if (gi == 0) begin : g_head
                assign src         = in_hdr;
                assign src_payload = payload;
                assign src_t_new   = t_new;
                assign bubble      = clr;
            end else begin : g_tail
                assign src         = hdr_q[gi-1];
                assign src_payload = payload_q[gi-1];
                assign src_t_new   = t_new_q[gi-1];
                assign bubble      = 1'b0;
            end

            pipe_slice #(
                .N_WORDS    (N_WORDS),
                .TNEW_W     (TNEW_W),
                .RESET_PC   (RESET_PC),
                .HANDLER_PC (HANDLER_PC)
            ) u_slice (
                .clk         (clk),
                .reset       (reset),
                .load        (en),
                .bubble      (bubble),
                .flush       (req_clr),
                .src         (src),
                .src_payload (src_payload),
                .src_t_new   (src_t_new),
                .slice_out   (hdr_q[gi]),
                .payload_out (payload_q[gi]),
                .t_new_out   (t_new_q[gi])
            );
        end
    endgenerate

    assign pc_n       = hdr_q[DEPTH-1].pc;
    assign instr_n    = hdr_q[DEPTH-1].instr;
    assign exc_code_n = hdr_q[DEPTH-1].exc_code;
    assign bd_n       = hdr_q[DEPTH-1].bd;
    assign valid_n    = hdr_q[DEPTH-1].valid;
    assign payload_n  = payload_q[DEPTH-1];
    assign fwd_t_new  = t_new_q[DEPTH-1];

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q + {31'd0, (~en & ~clr & ~req_clr)};
        bubble_cnt_d = bubble_cnt_q + {31'd0, (clr | req_clr)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a DEPTH=1 and a DEPTH=3 instance share stimulus and
// are compared every edge against a slice-list reference model.
module tb_pipe_stage_reg;

    localparam int NW = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          reset, en, clr, req_clr, bd;
    logic [31:0]   pc, instr;
    logic [127:0]  payload;
    logic [TW-1:0] t_new;
    logic [4:0]    exc_code;

    logic [31:0]   pc_a, instr_a, pc_b, instr_b;
    logic [127:0]  pl_a, pl_b;
    logic [TW-1:0] tn_a, tn_b;
    logic [4:0]    exc_a, exc_b;
    logic          bd_a, bd_b, v_a, v_b;
`ifdef PIPE_STAGE_STAT_EN
    logic [31:0]   stall_a, bub_a, stall_b, bub_b;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.N_WORDS(NW), .DEPTH(1), .TNEW_W(TW)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .req_clr(req_clr),
        .pc(pc), .instr(instr), .payload(payload), .t_new(t_new),
        .exc_code(exc_code), .bd(bd),
        .pc_n(pc_a), .instr_n(instr_a), .payload_n(pl_a), .fwd_t_new(tn_a),
        .exc_code_n(exc_a), .bd_n(bd_a), .valid_n(v_a)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt(stall_a), .bubble_cnt(bub_a)
`endif
    );

    pipe_stage_reg #(.N_WORDS(NW), .DEPTH(3), .TNEW_W(TW)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .req_clr(req_clr),
        .pc(pc), .instr(instr), .payload(payload), .t_new(t_new),
        .exc_code(exc_code), .bd(bd),
        .pc_n(pc_b), .instr_n(instr_b), .payload_n(pl_b), .fwd_t_new(tn_b),
        .exc_code_n(exc_b), .bd_n(bd_b), .valid_n(v_b)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt(stall_b), .bubble_cnt(bub_b)
`endif
    );

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  instr;
        logic [127:0] pl;
        int           tn;
        logic [4:0]   exc;
        logic         bd;
        logic         valid;
    } ent_t;

    ent_t m [2][3];
    int   dep [2] = '{1, 3};
    int   stall_m, bub_m;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t fixed_ent(input logic [31:0] p);
        ent_t e;
        e.pc = p; e.instr = '0; e.pl = '0; e.tn = 0; e.exc = '0; e.bd = 1'b0; e.valid = 1'b0;
        return e;
    endfunction

    // A load passes the entry through with T_new one closer to ready (floor 0)
    function automatic ent_t pass(input ent_t s);
        ent_t e = s;
        e.tn = (s.tn > 0) ? s.tn - 1 : 0;
        return e;
    endfunction

    task automatic model_step();
        ent_t in_e;
        in_e.pc = pc; in_e.instr = instr; in_e.pl = payload; in_e.tn = int'(t_new);
        in_e.exc = exc_code; in_e.bd = bd; in_e.valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < dep[k]; i++) m[k][i] = fixed_ent(32'h0000_3000);
            end else if (req_clr) begin
                for (int i = 0; i < dep[k]; i++) m[k][i] = fixed_ent(32'h0000_4180);
            end else begin
                for (int i = dep[k] - 1; i >= 1; i--) if (en) m[k][i] = pass(m[k][i-1]);
                if (clr) begin
                    m[k][0] = fixed_ent(pc);
                    m[k][0].bd = bd;
                end else if (en) begin
                    m[k][0] = pass(in_e);
                end
            end
        end
        if (reset) begin
            stall_m = 0; bub_m = 0;
        end else begin
            if (!en && !clr && !req_clr) stall_m++;
            if (clr || req_clr) bub_m++;
        end
    endtask

    task automatic cycle(input string what);
        model_step();
        @(posedge clk);
        #1;
        check({what, ".a.pc"},   128'(pc_a),    128'(m[0][0].pc));
        check({what, ".a.ins"},  128'(instr_a), 128'(m[0][0].instr));
        check({what, ".a.pl"},   pl_a,          m[0][0].pl);
        check({what, ".a.tn"},   128'(tn_a),    128'(m[0][0].tn));
        check({what, ".a.exc"},  128'(exc_a),   128'(m[0][0].exc));
        check({what, ".a.bd"},   128'(bd_a),    128'(m[0][0].bd));
        check({what, ".a.v"},    128'(v_a),     128'(m[0][0].valid));
        check({what, ".b.pc"},   128'(pc_b),    128'(m[1][2].pc));
        check({what, ".b.ins"},  128'(instr_b), 128'(m[1][2].instr));
        check({what, ".b.pl"},   pl_b,          m[1][2].pl);
        check({what, ".b.tn"},   128'(tn_b),    128'(m[1][2].tn));
        check({what, ".b.exc"},  128'(exc_b),   128'(m[1][2].exc));
        check({what, ".b.bd"},   128'(bd_b),    128'(m[1][2].bd));
        check({what, ".b.v"},    128'(v_b),     128'(m[1][2].valid));
`ifdef PIPE_STAGE_STAT_EN
        check({what, ".a.stall"}, 128'(stall_a), 128'(stall_m));
        check({what, ".a.bub"},   128'(bub_a),   128'(bub_m));
        check({what, ".b.stall"}, 128'(stall_b), 128'(stall_m));
        check({what, ".b.bub"},   128'(bub_b),   128'(bub_m));
`endif
        $display("[TB] %s rst=%b rq=%b clr=%b en=%b pc_in=%h | a: pc=%h v=%b tn=%0d | b: pc=%h v=%b tn=%0d",
                 what, reset, req_clr, clr, en, pc, pc_a, v_a, tn_a, pc_b, v_b, tn_b);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; req_clr = 1'b0;
        pc = 32'h1234_5678; instr = 32'hFFFF_FFFF; payload = '1;
        t_new = 3'd5; exc_code = 5'd7; bd = 1'b1;
        cycle("reset");
        check("reset.pc_const", 128'(pc_a), 128'h3000);
        check("reset.b_pc_const", 128'(pc_b), 128'h3000);

        reset = 1'b0; en = 1'b1; pc = 32'h3004; instr = 32'h0000_0001;
        payload = '0; payload[63:32] = 32'hDEAD_BEEF; t_new = 3'd2; exc_code = 5'd0; bd = 1'b0;
        cycle("advance");
        check("advance.w1_const", 128'(pl_a[63:32]), 128'hDEAD_BEEF);
        check("advance.tn_const", 128'(tn_a), 128'd1);

        pc = 32'h3008; t_new = 3'd0;
        cycle("adv_tn0");
        check("adv_tn0.tn_const", 128'(tn_a), 128'd0);

        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = $urandom; instr = $urandom; t_new = TW'($urandom);
            cycle("stall");
        end
        check("stall.pc_const", 128'(pc_a), 128'h3008);

        en = 1'b1; clr = 1'b1; pc = 32'h300C; bd = 1'b1; instr = 32'h2401_0001; exc_code = 5'd4;
        cycle("bubble");
        check("bubble.exc_const", 128'(exc_a), 128'd0);
        en = 1'b0;
        cycle("bubble_stall");
        check("bubble_stall.pc_const", 128'(pc_a), 128'h300C);

        req_clr = 1'b1;
        cycle("flush");
        check("flush.b_pc_const", 128'(pc_b), 128'h4180);

        req_clr = 1'b0; clr = 1'b0; en = 1'b1; t_new = 3'd3; pc = 32'h3010;
        bd = 1'b0; exc_code = 5'd0; instr = 32'h0000_0002;
        for (int i = 0; i < 3; i++) cycle("depth");
        check("depth.b_tn_const", 128'(tn_b), 128'd0);
        check("depth.b_v_const", 128'(v_b), 128'd1);

        for (int i = 0; i < 300; i++) begin
            reset    = ($urandom_range(99) < 3);
            req_clr  = ($urandom_range(99) < 6);
            clr      = ($urandom_range(99) < 15);
            en       = ($urandom_range(99) < 75);
            pc       = {$urandom_range(32'hFFFF), 2'b00} + 32'h3000;
            instr    = $urandom;
            payload  = {$urandom, $urandom, $urandom, $urandom};
            t_new    = TW'($urandom);
            exc_code = 5'($urandom);
            bd       = 1'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
